// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory: packs three bytes big-endian
// into each 24-bit word and writes words from address 0 while holding the CPU.
module instr_mem_loader #(
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   WordCount,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WrEn,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [WORD_WIDTH-1:0] WrData,
  output logic                  Busy,
  output logic                  CpuHold,
  output logic                  Done
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t state, state_next;

  logic [ADDR_WIDTH:0] target;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] word_inc;
  logic [ADDR_WIDTH:0] clamped;
  logic [1:0]          byte_cnt;
  logic [15:0]         word_buf;
  logic                take;

  assign take     = ByteValid && ByteReady;
  assign word_inc = word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
  // Clamp so the final write lands on the last address, never wrapping
  assign clamped  = (WordCount > MAX_WORDS) ? MAX_WORDS : WordCount;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (Start)
          state_next = (clamped == '0) ? DONE : COLLECT;
      COLLECT:
        if (take && byte_cnt == 2'd2)
          state_next = WRITE;
      WRITE:
        state_next = (word_inc == target) ? DONE : COLLECT;
      DONE:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      target    <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      WrAddr    <= '0;
      WrData    <= '0;
      ByteReady <= 1'b0;
      WrEn      <= 1'b0;
      Busy      <= 1'b0;
      CpuHold   <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_next;
      ByteReady <= (state_next == COLLECT);
      WrEn      <= (state_next == WRITE);
      Busy      <= (state_next != IDLE);
      CpuHold   <= (state_next != IDLE);
      Done      <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (Start) begin
            target   <= clamped;
            word_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        COLLECT: begin
          if (take) begin
            case (byte_cnt)
              2'd0: begin
                word_buf[15:8] <= ByteIn;
                byte_cnt       <= 2'd1;
              end
              2'd1: begin
                word_buf[7:0] <= ByteIn;
                byte_cnt      <= 2'd2;
              end
              default: begin
                WrData   <= {word_buf, ByteIn};
                WrAddr   <= word_cnt[ADDR_WIDTH-1:0];
                byte_cnt <= 2'd0;
              end
            endcase
          end
        end
        WRITE: begin
          word_cnt <= word_inc;
          byte_cnt <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: write order, data, latency,
// stalls, empty loads, mid-load reset and address clamping.
module tb_instr_mem_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WrEn;
  logic [7:0]  WrAddr;
  logic [23:0] WrData;
  logic        Busy;
  logic        CpuHold;
  logic        Done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  wa_q[$];
  logic [23:0] wd_q[$];
  int          wc_q[$];
  int          acc_q[$];
  int          done_n;
  int          done_cyc;
  int          fall_cyc;
  int          overlap;
  bit          ready_seen;
  bit          busy_prev;

  instr_mem_loader dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .WordCount(WordCount),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .Busy(Busy),
    .CpuHold(CpuHold),
    .Done(Done)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (ByteValid && ByteReady) acc_q.push_back(cyc);
    if (WrEn) begin
      wa_q.push_back(WrAddr);
      wd_q.push_back(WrData);
      wc_q.push_back(cyc);
    end
    if (WrEn && ByteReady) overlap++;
    if (ByteReady) ready_seen = 1'b1;
    if (Done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy_prev && !Busy) fall_cyc = cyc;
    busy_prev = Busy;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    acc_q.delete();
    done_n = 0;
    done_cyc = -1;
    fall_cyc = -1;
    overlap = 0;
    ready_seen = 1'b0;
  endtask

  task automatic start(input logic [8:0] n, output int s);
    Start = 1'b1;
    WordCount = n;
    s = cyc;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ByteValid = 1'b0;
    repeat (gap) tick();
    ByteIn = b;
    ByteValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ByteReady) ok = 1'b1;
      tick();
    end
    ByteValid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL byte_accept_timeout byte=%0h", b);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (done_n > 0) ok = 1'b1;
      else tick();
    end
    tick();
    tick();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    WordCount = '0;
    ByteIn = '0;
    ByteValid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (ByteReady !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", ByteReady);
    end
    checks++;
    if (WrEn !== 1'b0) begin
      failures++;
      $display("FAIL rst_wren got=%b exp=0", WrEn);
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b exp=0", Busy);
    end
    checks++;
    if (CpuHold !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold got=%b exp=0", CpuHold);
    end
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got=%b exp=0", Done);
    end
    checks++;
    if (WrAddr !== 8'h00) begin
      failures++;
      $display("FAIL rst_addr got=%0h exp=0", WrAddr);
    end
    checks++;
    if (WrData !== 24'h0) begin
      failures++;
      $display("FAIL rst_data got=%0h exp=0", WrData);
    end
  endtask

  task automatic run_two(input int gap, input string tag);
    logic [7:0] bytes [6];
    int s;
    bytes = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    clear();
    start(9'd2, s);
    checks++;
    if (Busy !== 1'b1 || CpuHold !== 1'b1) begin
      failures++;
      $display("FAIL %s_hold got=%b%b exp=11", tag, Busy, CpuHold);
    end
    for (int i = 0; i < 6; i++) send_byte(bytes[i], gap);
    wait_done();
    checks++;
    if (wa_q.size() != 2) begin
      failures++;
      $display("FAIL %s_nwrites got=%0d exp=2", tag, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 8'd0 || wd_q[0] !== 24'h123456) begin
        failures++;
        $display("FAIL %s_w0 got=%0h:%0h exp=0:123456",
                 tag, wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 8'd1 || wd_q[1] !== 24'hABCDEF) begin
        failures++;
        $display("FAIL %s_w1 got=%0h:%0h exp=1:abcdef",
                 tag, wa_q[1], wd_q[1]);
      end
      checks++;
      if (acc_q.size() != 6) begin
        failures++;
        $display("FAIL %s_naccept got=%0d exp=6", tag, acc_q.size());
      end else begin
        checks++;
        if (wc_q[0] != acc_q[2] + 1) begin
          failures++;
          $display("FAIL %s_lat0 got=%0d exp=%0d",
                   tag, wc_q[0], acc_q[2] + 1);
        end
        checks++;
        if (wc_q[1] != acc_q[5] + 1) begin
          failures++;
          $display("FAIL %s_lat1 got=%0d exp=%0d",
                   tag, wc_q[1], acc_q[5] + 1);
        end
      end
      checks++;
      if (done_cyc != wc_q[1] + 1) begin
        failures++;
        $display("FAIL %s_done got=%0d exp=%0d",
                 tag, done_cyc, wc_q[1] + 1);
      end
    end
    checks++;
    if (fall_cyc != done_cyc + 1) begin
      failures++;
      $display("FAIL %s_busyfall got=%0d exp=%0d",
               tag, fall_cyc, done_cyc + 1);
    end
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL %s_ready_in_write got=%0d exp=0", tag, overlap);
    end
    checks++;
    if (done_n != 1) begin
      failures++;
      $display("FAIL %s_ndone got=%0d exp=1", tag, done_n);
    end
  endtask

  task automatic test_back_to_back();
    run_two(0, "b2b");
  endtask

  task automatic test_stall();
    run_two(3, "stall");
  endtask

  task automatic test_zero();
    int s;
    clear();
    start(9'd0, s);
    wait_done();
    checks++;
    if (wa_q.size() != 0) begin
      failures++;
      $display("FAIL zero_writes got=%0d exp=0", wa_q.size());
    end
    checks++;
    if (done_cyc != s + 1) begin
      failures++;
      $display("FAIL zero_done got=%0d exp=%0d", done_cyc, s + 1);
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      failures++;
      $display("FAIL zero_ready got=%b exp=0", ready_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [5];
    int s;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    clear();
    start(9'd2, s);
    for (int i = 0; i < 5; i++) send_byte(bytes[i], 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || ByteReady !== 1'b0 || WrEn !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_idle got=%b%b%b exp=000",
               Busy, ByteReady, WrEn);
    end
    checks++;
    if (WrData !== 24'h0) begin
      failures++;
      $display("FAIL mid_rst_data got=%0h exp=0", WrData);
    end
    repeat (4) tick();
    checks++;
    if (wa_q.size() != 1) begin
      failures++;
      $display("FAIL mid_nwrites got=%0d exp=1", wa_q.size());
    end else begin
      checks++;
      if (wd_q[0] !== 24'h010203) begin
        failures++;
        $display("FAIL mid_w0 got=%0h exp=010203", wd_q[0]);
      end
    end
    clear();
    start(9'd1, s);
    send_byte(8'h0A, 0);
    send_byte(8'h0B, 0);
    send_byte(8'h0C, 0);
    wait_done();
    checks++;
    if (wa_q.size() != 1) begin
      failures++;
      $display("FAIL reload_nwrites got=%0d exp=1", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 8'd0 || wd_q[0] !== 24'h0A0B0C) begin
        failures++;
        $display("FAIL reload_w0 got=%0h:%0h exp=0:0a0b0c",
                 wa_q[0], wd_q[0]);
      end
    end
  endtask

  task automatic test_clamp();
    int s;
    int bad_addr;
    int bad_data;
    logic [7:0] k0;
    logic [23:0] exp_w;
    clear();
    start(9'd300, s);
    for (int k = 0; k < 768; k++) begin
      k0 = k[7:0];
      if (k == 300) begin
        Start = 1'b1;
        WordCount = 9'd5;
      end
      send_byte(k0, 0);
      Start = 1'b0;
    end
    wait_done();
    checks++;
    if (wa_q.size() != 256) begin
      failures++;
      $display("FAIL clamp_nwrites got=%0d exp=256", wa_q.size());
    end else begin
      bad_addr = 0;
      bad_data = 0;
      for (int i = 0; i < 256; i++) begin
        exp_w = {8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2)};
        if (wa_q[i] !== 8'(i)) bad_addr++;
        if (wd_q[i] !== exp_w) bad_data++;
      end
      checks++;
      if (bad_addr != 0) begin
        failures++;
        $display("FAIL clamp_addr_order got=%0d exp=0", bad_addr);
      end
      checks++;
      if (bad_data != 0) begin
        failures++;
        $display("FAIL clamp_data got=%0d exp=0", bad_data);
      end
    end
    repeat (6) tick();
    checks++;
    if (done_n != 1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_end got=%0d:%b exp=1:0", done_n, Busy);
    end
  endtask

  initial begin
    clear();
    busy_prev = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_zero();
    test_reset_mid();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer-side counterpart to the instruction memory read port: accepts a byte stream over a valid/ready handshake, assembles 24-bit instruction words big-endian, and issues one write per word into instruction memory starting at address 0. Sits between the boot/debug byte source and the instruction memory write port. Holds the CPU (CpuHold) while loading and pulses Done on completion.

Parameters:
WORD_WIDTH, 24, instruction width in bits; fixed at 3 bytes per word
ADDR_WIDTH, 8, instruction memory address width (depth 2^ADDR_WIDTH words)

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin a load; sampled only in IDLE
WordCount  input  ADDR_WIDTH+1  number of words to load; sampled with Start
ByteIn  input  8  stream data byte
ByteValid  input  1  ByteIn valid
ByteReady  output  1  loader can accept a byte this cycle
WrEn  output  1  instruction memory write strobe
WrAddr  output  ADDR_WIDTH  instruction memory write address
WrData  output  WORD_WIDTH  instruction word to write
Busy  output  1  high in any state except IDLE
CpuHold  output  1  equals Busy; keeps CPU fetch stalled
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (any state, including mid-word): state IDLE; ByteReady, WrEn, Busy, CpuHold, Done = 0; WrAddr = 0; WrData = 0; byte counter = 0; word counter = 0; partial word discarded. Words already written are not undone.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: ByteReady = 0. Start=1 latches target = min(WordCount, 2^ADDR_WIDTH). Target 0 -> DONE; otherwise -> COLLECT with byte counter 0, word counter 0.
- COLLECT: ByteReady = 1. Byte accepted only when ByteValid && ByteReady. Byte 0 -> WrData[23:16], byte 1 -> [15:8], byte 2 -> [7:0]. ByteValid low: hold, no state change. On acceptance of byte 2 -> WRITE.
- WRITE: exactly one cycle. WrEn = 1, WrAddr = word counter, WrData = assembled word; ByteReady = 0 (bytes not accepted). Next cycle: word counter +1, byte counter 0; if word counter +1 == target -> DONE, else -> COLLECT.
- DONE: Done = 1 for exactly one cycle, Busy still 1; then -> IDLE.
- Outputs registered. Latency: third byte accepted on edge N -> WrEn high in cycle N+1. Minimum 4 cycles per word (3 byte + 1 write).
- WrEn is 0 in every state except WRITE. WrAddr/WrData hold their last values outside WRITE.
- Start while Busy: ignored; WordCount changes during a load have no effect.
- Start and Reset in the same cycle: Reset wins.
- Address wrap: never occurs; target clamped so the last write is address 2^ADDR_WIDTH-1.
- Byte stream stalls are unbounded; no timeout.

Test Plan:
- Reset held 2 cycles then released -> ByteReady=0, WrEn=0, Busy=0, CpuHold=0, Done=0, WrAddr=0, WrData=0.
- Start with WordCount=2, bytes 0x12,0x34,0x56,0xAB,0xCD,0xEF back-to-back -> WrEn at addr 0 data 0x123456, then addr 1 data 0xABCDEF, each 1 cycle after the third byte; Done one cycle after the second write; Busy falls the cycle after Done.
- Same load with ByteValid low for 3 cycles between every byte -> identical writes and data; no byte accepted while ByteValid=0 or during WRITE.
- Start with WordCount=0 -> no WrEn, Done pulses the cycle after Start, ByteReady never asserted.
- Reset asserted after 2 bytes of word 1 (word 0 = 0x010203 already written) -> IDLE next cycle, no further WrEn; new Start with WordCount=1 and bytes 0x0A,0x0B,0x0C -> write addr 0 data 0x0A0B0C.
- ADDR_WIDTH=8, WordCount=300 -> exactly 256 writes, addresses 0..255 in order, then Done; Start pulsed mid-load ignored.
